// File: rtl/pdm_pair_tx.sv
// Dual-channel first-order sigma-delta PDM transmitter.
// One PCM sample feeds OSR bits; one channel lags the other by a set number of bits.
module pdm_pair_tx #(
  parameter int DIV       = 4,
  parameter int OSR       = 16,
  parameter int SAMPLE_W  = 8,
  parameter int MAX_DELAY = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [7:0]          delay,
  input  logic                delay_dir,
  input  logic                underrun_clr,
  output logic                pdm_clk,
  output logic                data_1,
  output logic                data_2,
  output logic                bit_strobe,
  output logic                underrun
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [7:0] DMAX = 8'(MAX_DELAY);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [SAMPLE_W-1:0]  acc_q, acc_d;
  logic [SAMPLE_W-1:0]  cur_q, cur_d;
  logic [SAMPLE_W-1:0]  nxt_q, nxt_d;
  logic                 nv_q, nv_d;
  logic [MAX_DELAY-1:0] dly_q, dly_d;
  logic                 d1_q, d1_d;
  logic                 d2_q, d2_d;
  logic                 stb_q;
  logic                 ur_q, ur_d;
  logic                 pclk_q, pclk_d;

  logic                 strobe;
  logic                 xfer;
  logic                 hs;
  logic                 r;
  logic                 delayed;
  logic [SAMPLE_W-1:0]  cur_eff;
  logic [SAMPLE_W:0]    sum;
  logic [7:0]           d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
      cur_q  <= '0;
      nxt_q  <= '0;
      nv_q   <= 1'b0;
      dly_q  <= '0;
      d1_q   <= 1'b0;
      d2_q   <= 1'b0;
      stb_q  <= 1'b0;
      ur_q   <= 1'b0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      cur_q  <= cur_d;
      nxt_q  <= nxt_d;
      nv_q   <= nv_d;
      dly_q  <= dly_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      stb_q  <= strobe;
      ur_q   <= ur_d;
      pclk_q <= pclk_d;
    end
  end

  always_comb begin
    strobe  = en && (cnt_q == CW'(DIV - 1));
    xfer    = strobe && (idx_q == '0);
    hs      = sample_valid && !nv_q;
    cur_eff = (xfer && nv_q) ? nxt_q : cur_q;
    sum     = {1'b0, acc_q} + {1'b0, cur_eff};
    r       = sum[SAMPLE_W];
    d       = (delay > DMAX) ? DMAX : delay;
    // delayed tap reads the pre-shift history
    delayed = r;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (d == 8'(i + 1)) delayed = dly_q[i];
    end
  end

  always_comb begin
    cnt_d = '0;
    if (en) cnt_d = strobe ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (strobe) begin
      idx_d = (idx_q == IW'(OSR - 1)) ? '0 : idx_q + IW'(1);
    end
    acc_d  = strobe ? sum[SAMPLE_W-1:0] : acc_q;
    cur_d  = cur_eff;
    nxt_d  = hs ? sample : nxt_q;
    nv_d   = hs ? 1'b1 : (xfer ? 1'b0 : nv_q);
    dly_d  = dly_q;
    if (strobe) dly_d = (dly_q << 1) | MAX_DELAY'(r);
    // a set in the same cycle overrides the clear
    ur_d   = (xfer && !nv_q) ? 1'b1 : (underrun_clr ? 1'b0 : ur_q);
    pclk_d = (cnt_d >= CW'(DIV / 2));
    d1_d   = d1_q;
    d2_d   = d2_q;
    if (strobe) begin
      d1_d = delay_dir ? delayed : r;
      d2_d = delay_dir ? r : delayed;
    end
  end

  assign sample_ready = ~nv_q;
  assign pdm_clk      = pclk_q;
  assign data_1       = d1_q;
  assign data_2       = d2_q;
  assign bit_strobe   = stb_q;
  assign underrun     = ur_q;

endmodule
